imem_loader: RTL and testbench

Writable instruction memory with a byte-stream loader. It is the write side of the core's instruction-fetch path. An external source (UART bridge or testbench) streams bytes over a valid/ready handshake. The block assembles them into N-bit words and writes them sequentially from address 0 into a 64-entry RAM. The core fetches through the same combinational read port it uses for the ROM. `busy` stalls the core while a load is in progress.

---
 rtl/imem_loader.sv | 180 ++++++++++++++++++
 tb/tb_imem_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: writable 64-entry instruction RAM fed by a byte stream.
// Optional trailing-checksum check: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [6:0]   count,
  input  logic         byte_valid,
  input  logic [7:0]   byte_data,
  output logic         byte_ready,
  output logic         busy,
  output logic         done,
  output logic         err,
  input  logic [5:0]   addr,
  output logic [N-1:0] q
);

  localparam int B  = N / 8;
  localparam int BW = (B > 1) ? $clog2(B) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(B - 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;
`endif

  state_t          r_state;
  logic [N-1:0]    r_mem [64];
  logic [6:0]      r_cnt;
  logic [6:0]      r_wcnt;
  logic [5:0]      r_wptr;
  logic [BW-1:0]   r_bidx;
  logic [N-1:0]    r_asm;
  logic            r_ready;
  logic            r_busy;
  logic            r_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      r_sum;
  logic            r_err;
`endif

  logic            w_xfer;
  logic            w_last;
  logic            w_we;
  logic [6:0]      w_wcnt_nx;
  logic            w_final;
  logic [N-1:0]    w_word;

  assign w_xfer    = (r_state == S_LOAD) && byte_valid && r_ready;
  assign w_last    = (r_bidx == LAST_IDX);
  // a reset on the same edge discards the word in flight
  assign w_we      = reset && w_xfer && w_last;
  assign w_wcnt_nx = r_wcnt + 7'd1;
  assign w_final   = w_we && (w_wcnt_nx == r_cnt);

  // Complete word: assembled low bytes plus the byte on the bus now
  always_comb begin
    w_word = r_asm;
    w_word[8*(B-1) +: 8] = byte_data;
  end

  // RAM write port; contents survive reset and persist across loads
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_wptr] <= w_word;
    end
  end

  // Loader FSM with registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 7'd0;
      r_wcnt  <= 7'd0;
      r_wptr  <= 6'd0;
      r_bidx  <= '0;
      r_asm   <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum   <= 8'd0;
      r_err   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_wcnt <= 7'd0;
          r_wptr <= 6'd0;
          r_bidx <= '0;
          r_asm  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          r_sum  <= 8'd0;
          r_err  <= 1'b0;
`endif
          if (start) begin
            r_cnt   <= (count == 7'd0) ? 7'd64 : count;
            r_state <= S_LOAD;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum <= r_sum + byte_data;
`endif
            if (w_last) begin
              r_bidx <= '0;
              r_wptr <= r_wptr + 6'd1;
              r_wcnt <= w_wcnt_nx;
              if (w_final) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_state <= S_CHECK;
`else
                r_state <= S_DONE;
                r_ready <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
`endif
              end
            end else begin
              r_asm[{r_bidx, 3'b000} +: 8] <= byte_data;
              r_bidx <= r_bidx + 1'b1;
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (byte_valid && r_ready) begin
            r_err   <= (byte_data != r_sum);
            r_state <= S_DONE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
`endif
        S_DONE: begin
          r_done  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          r_err   <= 1'b0;
`endif
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = r_ready;
  assign busy       = r_busy;
  assign done       = r_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign err        = r_err;
`else
  assign err        = 1'b0;
`endif

  // Fetch port: old word during the write cycle, new word afterwards
  assign q = r_mem[addr];

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader.
// Also exercises the checksum path when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        busy;
  logic        done;
  logic        err;
  logic [5:0]  addr;
  logic [31:0] q;

  imem_loader #(.N(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .count      (count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .addr       (addr),
    .q          (q)
  );

  always #5 clk = ~clk;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CKB = 1;
`else
  localparam int CKB = 0;
`endif

  typedef struct {
    string       nm;
    logic [5:0]  a;
    logic [31:0] d;
  } rd_t;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          done_cnt = 0;
  int          t_rdy    = 0;
  int          busy_low = 0;
  logic        last_err;
  logic [7:0]  tb_bytes [256];
  rd_t         vec [4];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] full_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {8'hC0, b, 8'h5A, ~b};
  endfunction

  task automatic set_word(input int w, input logic [31:0] v);
    for (int k = 0; k < 4; k++) tb_bytes[4*w+k] = v[8*k +: 8];
  endtask

  task automatic rd(input string nm, input logic [5:0] a,
                    input logic [31:0] exp);
    addr = a;
    #1;
    chk(nm, {32'd0, q}, {32'd0, exp});
  endtask

  task automatic do_start(input logic [6:0] c);
    start = 1'b1;
    count = c;
    step();
    start = 1'b0;
    t_rdy = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    int k;
    byte_valid = 1'b0;
    repeat (stall) begin
      if (!busy) busy_low++;
      step();
    end
    byte_valid = 1'b1;
    byte_data  = b;
    k = 0;
    while (!byte_ready && k < 50) begin
      step();
      k++;
    end
    if (!byte_ready) chk("ready_timeout", {63'd0, byte_ready}, 64'd1);
    if (!busy) busy_low++;
    step();
    byte_valid = 1'b0;
  endtask

  task automatic stream(input int nb, input int stall, input int ck);
    logic [7:0] sum;
    int k;
    sum = 8'd0;
    busy_low = 0;
    for (int i = 0; i < nb; i++) begin
      send_byte(tb_bytes[i], (i == 0) ? 0 : stall);
      sum = sum + tb_bytes[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte((ck < 0) ? sum : 8'(ck), stall);
`endif
    k = 0;
    while (!done && k < 20) begin
      step();
      k++;
    end
    chk("done_seen", {63'd0, done}, 64'd1);
    last_err = err;
    if (stall == 0) chk("done_latency", 64'(cyc - t_rdy), 64'(nb + CKB));
    step();
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("idle_busy", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int d0;
    reset      = 1'b0;
    start      = 1'b1;
    count      = 7'd0;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    addr       = 6'd0;
    vec[0] = '{"two_q0",  6'd0,  32'hF8000001};
    vec[1] = '{"two_q1",  6'd1,  32'hF8008002};
    vec[2] = '{"two_q2",  6'd2,  full_word(2)};
    vec[3] = '{"two_q63", 6'd63, full_word(63)};

    // reset held with start asserted
    step();
    step();
    chk("rst_busy",  {63'd0, busy},       64'd0);
    chk("rst_ready", {63'd0, byte_ready}, 64'd0);
    chk("rst_done",  {63'd0, done},       64'd0);
    chk("rst_err",   {63'd0, err},        64'd0);

    // release: start (count=0 -> 64 words) accepted on next edge
    for (int w = 0; w < 64; w++) set_word(w, full_word(w));
    reset = 1'b1;
    step();
    start = 1'b0;
    t_rdy = cyc;
    chk("start_busy",  {63'd0, busy},       64'd1);
    chk("start_ready", {63'd0, byte_ready}, 64'd1);
    stream(256, 0, -1);
    for (int w = 0; w < 64; w++) rd("full", 6'(w), full_word(w));

    // count=1 overwrites only address 0
    set_word(0, 32'h0BADF00D);
    do_start(7'd1);
    stream(4, 0, -1);
    rd("one_q0",  6'd0,  32'h0BADF00D);
    rd("one_q1",  6'd1,  full_word(1));
    rd("one_q63", 6'd63, full_word(63));

    // two-word load, back-to-back
    tb_bytes[0] = 8'h01; tb_bytes[1] = 8'h00;
    tb_bytes[2] = 8'h00; tb_bytes[3] = 8'hF8;
    tb_bytes[4] = 8'h02; tb_bytes[5] = 8'h80;
    tb_bytes[6] = 8'h00; tb_bytes[7] = 8'hF8;
    do_start(7'd2);
    stream(8, 0, -1);
    chk("two_err", {63'd0, last_err}, 64'd0);
    for (int i = 0; i < 4; i++) rd(vec[i].nm, vec[i].a, vec[i].d);

    // scramble, then reload the same words with a stalling source
    set_word(0, 32'hEEEEEEEE);
    set_word(1, 32'hDDDDDDDD);
    do_start(7'd2);
    stream(8, 0, -1);
    rd("scr_q0", 6'd0, 32'hEEEEEEEE);
    set_word(0, 32'hF8000001);
    set_word(1, 32'hF8008002);
    d0 = done_cnt;
    do_start(7'd2);
    stream(8, 2, -1);
    chk("stall_busy_held", 64'(busy_low), 64'd0);
    chk("stall_done_once", 64'(done_cnt - d0), 64'd1);
    rd("stall_q0", 6'd0, 32'hF8000001);
    rd("stall_q1", 6'd1, 32'hF8008002);

    // reset after 6 bytes; stray start during the load is ignored
    d0 = done_cnt;
    do_start(7'd2);
    send_byte(8'hDD, 0);
    send_byte(8'hCC, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hAA, 0);
    start = 1'b1;
    count = 7'd1;
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    start = 1'b0;
    chk("mid_busy", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("mid_rst_busy",  {63'd0, busy},       64'd0);
    chk("mid_rst_ready", {63'd0, byte_ready}, 64'd0);
    chk("mid_no_done", 64'(done_cnt - d0), 64'd0);
    rd("mid_q0", 6'd0, 32'hAABBCCDD);
    rd("mid_q1", 6'd1, 32'hF8008002);

    // after the abort a new load starts again at address 0
    set_word(0, 32'h55667788);
    do_start(7'd1);
    stream(4, 0, -1);
    rd("post_q0", 6'd0, 32'h55667788);
    rd("post_q1", 6'd1, 32'hF8008002);

`ifdef IMEM_LOADER_CHECKSUM_EN
    set_word(0, 32'h04030201);
    do_start(7'd1);
    stream(4, 0, 8'h0A);
    chk("ck_good_err", {63'd0, last_err}, 64'd0);
    set_word(0, 32'h04030201);
    do_start(7'd1);
    stream(4, 0, 8'h0B);
    chk("ck_bad_err", {63'd0, last_err}, 64'd1);
    rd("ck_q0", 6'd0, 32'h04030201);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
